// File: rtl/div_r2_param_if.sv
// Request/result bundle for the radix-2 divider: operands in, quotient/remainder out.
interface div_r2_param_if #(
   parameter int unsigned WIDTH = 32
);
   logic             valid_in;
   logic [WIDTH-1:0] zdividend;
   logic [WIDTH-1:0] zdivisor;
   logic             sign;
   logic             out_ready;
   logic             free;
   logic             done;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             sign_o;
   logic             div_zero;

   modport master (
      output valid_in, zdividend, zdivisor, sign, out_ready,
      input  free, done, q, r, sign_o, div_zero
   );

   modport slave (
      input  valid_in, zdividend, zdivisor, sign, out_ready,
      output free, done, q, r, sign_o, div_zero
   );
endinterface

// File: rtl/div_r2_param.sv
// Iterative radix-2 restoring divider, signed/unsigned, truncating semantics.
// Optional macro DIV_R2_EARLY_TERM_EN skips leading-zero iterations via divisor pre-shift.
module div_r2_param #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned EXPWIDTH = 6
) (
   input logic          clk,
   input logic          rst_n,
   div_r2_param_if.slave bus
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] NORM  = 3'd1;
   localparam logic [2:0] ITER  = 3'd2;
   localparam logic [2:0] FIXUP = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

`ifdef DIV_R2_EARLY_TERM_EN
   localparam int unsigned DW = WIDTH;
`else
   localparam int unsigned DW = 2 * WIDTH - 1;
`endif

   logic [2:0]          state, state_nxt;
   logic [WIDTH-1:0]    opa, opb;
   logic                sgn;
   logic [WIDTH-1:0]    rem, quo;
   logic [DW-1:0]       dsr;
   logic [EXPWIDTH-1:0] cnt;
   logic                q_neg, r_neg, dz;
   logic                free_st, done_st, sign_res, dz_res;
   logic [WIDTH-1:0]    q_res, r_res;

   logic [WIDTH-1:0]    abs_a_c, abs_b_c, rem_sub_c;
   logic [DW-1:0]       dsr_init_c;
   logic [EXPWIDTH-1:0] iters_c;
   logic                ge_c;

`ifdef DIV_R2_EARLY_TERM_EN
   logic [EXPWIDTH-1:0] lzd_c, lzs_c;

   function automatic logic [EXPWIDTH-1:0] lzc(input logic [WIDTH-1:0] v);
      lzc = EXPWIDTH'(WIDTH);
      for (int i = 0; i < int'(WIDTH); i++)
         if (v[i]) lzc = EXPWIDTH'(int'(WIDTH) - 1 - i);
   endfunction
`endif

   // Magnitudes, divisor alignment and iteration count prepared while in NORM
   always_comb begin
      abs_a_c = (sgn && opa[WIDTH-1]) ? -opa : opa;
      abs_b_c = (sgn && opb[WIDTH-1]) ? -opb : opb;
`ifdef DIV_R2_EARLY_TERM_EN
      lzd_c = lzc(abs_a_c);
      lzs_c = lzc(abs_b_c);
      if (abs_a_c >= abs_b_c) begin
         iters_c    = lzs_c - lzd_c + EXPWIDTH'(1);
         dsr_init_c = abs_b_c << (lzs_c - lzd_c);
      end else begin
         iters_c    = '0;
         dsr_init_c = abs_b_c;
      end
`else
      iters_c    = EXPWIDTH'(WIDTH);
      dsr_init_c = {abs_b_c, {(WIDTH-1){1'b0}}};
`endif
      ge_c      = (DW'(rem) >= dsr);
      rem_sub_c = rem - dsr[WIDTH-1:0];
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.valid_in) state_nxt = NORM;
         NORM:    state_nxt = (opb == '0 || iters_c == '0) ? FIXUP : ITER;
         ITER:    if (cnt == EXPWIDTH'(1)) state_nxt = FIXUP;
         FIXUP:   state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         free_st <= 1'b1;
         done_st <= 1'b0;
      end else begin
         state   <= state_nxt;
         free_st <= (state_nxt == IDLE);
         done_st <= (state_nxt == DONE);
      end
   end

   // Datapath: operand capture, shift/subtract steps and sign fix-up
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         opa      <= '0;
         opb      <= '0;
         sgn      <= 1'b0;
         rem      <= '0;
         quo      <= '0;
         dsr      <= '0;
         cnt      <= '0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         dz       <= 1'b0;
         q_res    <= '0;
         r_res    <= '0;
         sign_res <= 1'b0;
         dz_res   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.valid_in) begin
                  opa <= bus.zdividend;
                  opb <= bus.zdivisor;
                  sgn <= bus.sign;
               end
            end
            NORM: begin
               rem   <= abs_a_c;
               dsr   <= dsr_init_c;
               quo   <= '0;
               cnt   <= iters_c;
               q_neg <= sgn & (opa[WIDTH-1] ^ opb[WIDTH-1]);
               r_neg <= sgn & opa[WIDTH-1];
               dz    <= (opb == '0);
            end
            ITER: begin
               if (ge_c) rem <= rem_sub_c;
               quo <= {quo[WIDTH-2:0], ge_c};
               dsr <= dsr >> 1;
               cnt <= cnt - EXPWIDTH'(1);
            end
            FIXUP: begin
               // r restores the original dividend when the divisor is zero
               q_res    <= dz ? '1 : (q_neg ? -quo : quo);
               r_res    <= r_neg ? -rem : rem;
               sign_res <= sgn;
               dz_res   <= dz;
            end
            default: ;
         endcase
      end
   end

   assign bus.free     = free_st;
   assign bus.done     = done_st;
   assign bus.q        = q_res;
   assign bus.r        = r_res;
   assign bus.sign_o   = sign_res;
   assign bus.div_zero = dz_res;
endmodule

// File: tb/tb_div_r2_param.sv
// Randomized bench for div_r2_param against an arithmetic reference model, plus directed literal cases.
module tb_div_r2_param;
   localparam int unsigned W      = 32;
   localparam int          N_RAND = 1200;

   logic clk;
   logic rst_n;

   div_r2_param_if #(.WIDTH(W)) bus ();

   div_r2_param #(.WIDTH(W), .EXPWIDTH(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          ncyc  = 0;
   int          t_req = 0;
   bit          chk_en = 1'b0;
   bit          pending = 1'b0;
   bit          got_done = 1'b0;
   logic [W-1:0] exp_q, exp_r;
   logic        exp_s, exp_dz;
   int          exp_lat;
   logic [W-1:0] cap_q, cap_r;
   logic        cap_s, cap_dz;
   int          cap_lat;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, got, want, ncyc);
      end
   endtask

   // Reference: truncating division in 64-bit arithmetic; latency from bit lengths
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
      longint sa, sb, aa, ab;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'b0, a});
         sb = longint'({32'b0, b});
      end
      aa = (sa < 0) ? -sa : sa;
      ab = (sb < 0) ? -sb : sb;
      if (b == '0) begin
         q   = '1;
         r   = a;
         lat = 2;
      end else begin
         q = W'(sa / sb);
         r = W'(sa % sb);
`ifdef DIV_R2_EARLY_TERM_EN
         if (aa < ab) lat = 2;
         else lat = $clog2(aa + 1) - $clog2(ab + 1) + 1 + 2;
`else
         lat = W + 2;
`endif
      end
   endtask

   // Compare process: every cycle done is high the held result must match the model
   always @(negedge clk) begin
      ncyc++;
      if (chk_en) begin
         if (bus.done) begin
            if (!pending) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_done: got done=1 want done=0 (cycle %0d)", ncyc);
            end else begin
               if (!got_done) begin
                  got_done = 1'b1;
                  cap_lat  = ncyc - t_req - 1;
                  cap_q    = bus.q;
                  cap_r    = bus.r;
                  cap_s    = bus.sign_o;
                  cap_dz   = bus.div_zero;
                  chk("latency", 64'(cap_lat), 64'(exp_lat));
               end
               chk("q", 64'(bus.q), 64'(exp_q));
               chk("r", 64'(bus.r), 64'(exp_r));
               chk("sign_o", 64'(bus.sign_o), 64'(exp_s));
               chk("div_zero", 64'(bus.div_zero), 64'(exp_dz));
               chk("free_in_done", 64'(bus.free), 64'(0));
            end
         end else if (pending && got_done && !bus.out_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL done_dropped: got done=0 want done=1 (cycle %0d)", ncyc);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
      int t = 0;
      while (!bus.free && t < 300) begin
         tick();
         t++;
      end
      if (!bus.free) chk("free_timeout", 64'(bus.free), 64'(1));
      bus.valid_in  = 1'b1;
      bus.zdividend = a;
      bus.zdivisor  = b;
      bus.sign      = s;
      model(a, b, s, exp_q, exp_r, exp_lat);
      exp_s    = s;
      exp_dz   = (b == '0);
      t_req    = ncyc;
      got_done = 1'b0;
      pending  = 1'b1;
      tick();
      bus.valid_in = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (!got_done && t < 300) begin
         tick();
         t++;
      end
      if (!got_done) chk("done_timeout", 64'(got_done), 64'(1));
   endtask

   task automatic release_res(input int hold);
      repeat (hold) tick();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      pending       = 1'b0;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 9))
         0:       pick = '0;
         1:       pick = W'(1);
         2:       pick = '1;
         3:       pick = 32'h8000_0000;
         4:       pick = 32'h7FFF_FFFF;
         5:       pick = W'($urandom_range(0, 15));
         6:       pick = W'($urandom >> $urandom_range(0, 31));
         default: pick = W'($urandom);
      endcase
   endfunction

   task automatic check_reset_state(input string tag);
      chk({tag, "_free"}, 64'(bus.free), 64'(1));
      chk({tag, "_done"}, 64'(bus.done), 64'(0));
      chk({tag, "_q"}, 64'(bus.q), 64'(0));
      chk({tag, "_r"}, 64'(bus.r), 64'(0));
      chk({tag, "_sign_o"}, 64'(bus.sign_o), 64'(0));
      chk({tag, "_div_zero"}, 64'(bus.div_zero), 64'(0));
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.valid_in  = 1'b0;
      bus.zdividend = '0;
      bus.zdivisor  = '0;
      bus.sign      = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      check_reset_state("reset");
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Unsigned 100/7 with literal expectations
      start_op(32'd100, 32'd7, 1'b0);
      wait_done();
      chk("lit_100_7_q", 64'(cap_q), 64'd14);
      chk("lit_100_7_r", 64'(cap_r), 64'd2);
`ifdef DIV_R2_EARLY_TERM_EN
      chk("lit_100_7_lat", 64'(cap_lat), 64'd7);
`else
      chk("lit_100_7_lat", 64'(cap_lat), 64'd34);
`endif
      release_res(0);

      start_op(32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_done();
      chk("lit_m7_2_q", 64'(cap_q), 64'hFFFF_FFFD);
      chk("lit_m7_2_r", 64'(cap_r), 64'hFFFF_FFFF);
      chk("lit_m7_2_sign_o", 64'(cap_s), 64'd1);
      release_res(1);

      start_op(32'd7, 32'hFFFF_FFFE, 1'b1);
      wait_done();
      chk("lit_7_m2_q", 64'(cap_q), 64'hFFFF_FFFD);
      chk("lit_7_m2_r", 64'(cap_r), 64'd1);
      release_res(0);

      for (int m = 0; m < 2; m++) begin
         start_op(32'd5, 32'd0, m[0]);
         wait_done();
         chk("lit_div0_q", 64'(cap_q), 64'hFFFF_FFFF);
         chk("lit_div0_r", 64'(cap_r), 64'd5);
         chk("lit_div0_flag", 64'(cap_dz), 64'd1);
         chk("lit_div0_lat", 64'(cap_lat), 64'd2);
         release_res(0);
      end

      start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_done();
      chk("lit_min_m1_q", 64'(cap_q), 64'h8000_0000);
      chk("lit_min_m1_r", 64'(cap_r), 64'd0);
      chk("lit_min_m1_flag", 64'(cap_dz), 64'd0);
      release_res(0);

      // Held result under back-pressure while a new request waits on valid_in
      start_op(32'd100, 32'd7, 1'b0);
      wait_done();
      bus.valid_in  = 1'b1;
      bus.zdividend = 32'd1000;
      bus.zdivisor  = 32'd3;
      bus.sign      = 1'b0;
      release_res(10);
      chk("held_no_accept_free", 64'(bus.free), 64'd1);
      start_op(32'd1000, 32'd3, 1'b0);
      wait_done();
      chk("lit_1000_3_q", 64'(cap_q), 64'd333);
      release_res(0);

      // Abort mid-iteration with a one-cycle reset
      start_op(32'd100, 32'd7, 1'b0);
      repeat (10) tick();
      rst_n   = 1'b0;
      pending = 1'b0;
      tick();
      check_reset_state("abort");
      rst_n = 1'b1;
      start_op(32'd100, 32'd7, 1'b0);
      wait_done();
      chk("post_abort_q", 64'(cap_q), 64'd14);
      chk("post_abort_r", 64'(cap_r), 64'd2);
      release_res(2);

      for (int i = 0; i < N_RAND; i++) begin
         logic [W-1:0] a, b;
         a = pick();
         b = pick();
         start_op(a, b, 1'($urandom_range(0, 1)));
         wait_done();
         release_res(int'($urandom_range(0, 3)));
      end

      repeat (5) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
